// File: rtl/viterbi_channel_err_inj_if.sv
// Symbol stream bundle between the convolutional encoder, the channel model and the Viterbi decoder.
// The master drives symbols and the injection enable; the slave returns channel symbols and statistics.
interface viterbi_channel_err_inj_if #(
   parameter int SYM_W = 2,
   parameter int CNT_W = 16
);
   logic             enable_i;
   logic [SYM_W-1:0] sym_i;
   logic             inj_en_i;
   logic [SYM_W-1:0] sym_o;
   logic             valid_o;
   logic [SYM_W-1:0] err_inj;
   logic [CNT_W-1:0] error_counter;
   logic [CNT_W-1:0] word_ct;

   modport master (
      output enable_i, sym_i, inj_en_i,
      input  sym_o, valid_o, err_inj, error_counter, word_ct
   );

   modport slave (
      input  enable_i, sym_i, inj_en_i,
      output sym_o, valid_o, err_inj, error_counter, word_ct
   );
endinterface

// File: rtl/viterbi_channel_err_inj.sv
// Channel model: registers encoded symbols and flips LFSR-selected bits, leaving an error-free gap after each hit.
// Define ERR_BURST_EN to allow double-bit bursts when lfsr[9] is set at an injection.
module viterbi_channel_err_inj #(
   parameter int          SYM_W     = 2,
   parameter int          CNT_W     = 16,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter logic [8:0]  THRESH    = 9'd16,
   parameter int          MIN_GAP   = 8
) (
   input logic                     clk,
   input logic                     rst,
   viterbi_channel_err_inj_if.slave bus
);

   localparam int GAP_W = $clog2(MIN_GAP + 1);
   localparam int POP_W = $clog2(SYM_W + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLDOFF
   } state_t;

   state_t           state, state_nxt;
   logic [GAP_W-1:0] gap, gap_nxt;
   logic [15:0]      lfsr, lfsr_nxt;
   logic [SYM_W-1:0] mask;
   logic [POP_W-1:0] pop;
   logic [CNT_W:0]   ec_sum;
   logic [CNT_W-1:0] ec_nxt;
   logic [CNT_W-1:0] wc_nxt;

   // Galois form of x^16+x^14+x^13+x^11+1, shifting towards bit 0.
   assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   // IDLE arms on any edge with inj_en_i high (like the drop to IDLE), so a
   // stream starting one cycle after enabling can be hit on its first symbol.
   always_comb begin
      state_nxt = state;
      gap_nxt   = gap;
      mask      = '0;
      if (!bus.inj_en_i) begin
         state_nxt = IDLE;
         gap_nxt   = '0;
      end else begin
         case (state)
            IDLE: state_nxt = RUN;
            RUN: begin
               if (bus.enable_i && ({1'b0, lfsr[7:0]} < THRESH)) begin
                  if (lfsr[8]) mask[1] = 1'b1;
                  else         mask[0] = 1'b1;
`ifdef ERR_BURST_EN
                  if (lfsr[9]) mask[1:0] = 2'b11;
`endif
                  state_nxt = HOLDOFF;
                  gap_nxt   = GAP_W'(MIN_GAP);
               end
            end
            HOLDOFF: begin
               if (bus.enable_i) begin
                  gap_nxt = gap - GAP_W'(1);
                  if (gap == GAP_W'(1)) state_nxt = RUN;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      pop = '0;
      for (int unsigned i = 0; i < SYM_W; i++) pop = pop + POP_W'(mask[i]);
   end

   // Both counters clamp at all-ones instead of wrapping.
   assign ec_sum = {1'b0, bus.error_counter} + (CNT_W + 1)'(pop);
   assign ec_nxt = ec_sum[CNT_W] ? '1 : ec_sum[CNT_W-1:0];
   assign wc_nxt = (&bus.word_ct) ? bus.word_ct : bus.word_ct + CNT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         gap   <= '0;
      end else begin
         state <= state_nxt;
         gap   <= gap_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr              <= LFSR_SEED;
         bus.sym_o         <= '0;
         bus.valid_o       <= 1'b0;
         bus.err_inj       <= '0;
         bus.error_counter <= '0;
         bus.word_ct       <= '0;
      end else if (bus.enable_i) begin
         lfsr              <= lfsr_nxt;
         bus.sym_o         <= bus.sym_i ^ mask;
         bus.valid_o       <= 1'b1;
         bus.err_inj       <= mask;
         bus.error_counter <= ec_nxt;
         bus.word_ct       <= wc_nxt;
      end else begin
         bus.valid_o <= 1'b0;
         bus.err_inj <= '0;
      end
   end

endmodule

// File: tb/tb_viterbi_channel_err_inj.sv
// Scoreboard bench: four channel instances (THRESH 0/16/256, and a 4-bit-counter MIN_GAP=1 variant) share one stimulus.
module tb_viterbi_channel_err_inj;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en  = 1'b0;
   logic [1:0] sym = 2'b00;
   logic       inj = 1'b0;

   always #5 clk = ~clk;

   viterbi_channel_err_inj_if #(.SYM_W(2), .CNT_W(16)) if0 ();
   viterbi_channel_err_inj_if #(.SYM_W(2), .CNT_W(16)) if1 ();
   viterbi_channel_err_inj_if #(.SYM_W(2), .CNT_W(16)) if2 ();
   viterbi_channel_err_inj_if #(.SYM_W(2), .CNT_W(4))  if3 ();

   viterbi_channel_err_inj #(.SYM_W(2), .CNT_W(16), .THRESH(9'd0),   .MIN_GAP(8))
      dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   viterbi_channel_err_inj #(.SYM_W(2), .CNT_W(16), .THRESH(9'd16),  .MIN_GAP(8))
      dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
   viterbi_channel_err_inj #(.SYM_W(2), .CNT_W(16), .THRESH(9'd256), .MIN_GAP(8))
      dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
   viterbi_channel_err_inj #(.SYM_W(2), .CNT_W(4),  .THRESH(9'd256), .MIN_GAP(1))
      dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   assign if0.enable_i = en;  assign if0.sym_i = sym;  assign if0.inj_en_i = inj;
   assign if1.enable_i = en;  assign if1.sym_i = sym;  assign if1.inj_en_i = inj;
   assign if2.enable_i = en;  assign if2.sym_i = sym;  assign if2.inj_en_i = inj;
   assign if3.enable_i = en;  assign if3.sym_i = sym;  assign if3.inj_en_i = inj;

   logic        v   [N];
   logic [1:0]  so  [N];
   logic [1:0]  ei  [N];
   logic [15:0] ecv [N];
   logic [15:0] wcv [N];

   assign v[0] = if0.valid_o;  assign so[0] = if0.sym_o;  assign ei[0] = if0.err_inj;
   assign v[1] = if1.valid_o;  assign so[1] = if1.sym_o;  assign ei[1] = if1.err_inj;
   assign v[2] = if2.valid_o;  assign so[2] = if2.sym_o;  assign ei[2] = if2.err_inj;
   assign v[3] = if3.valid_o;  assign so[3] = if3.sym_o;  assign ei[3] = if3.err_inj;
   assign ecv[0] = if0.error_counter;  assign wcv[0] = if0.word_ct;
   assign ecv[1] = if1.error_counter;  assign wcv[1] = if1.word_ct;
   assign ecv[2] = if2.error_counter;  assign wcv[2] = if2.word_ct;
   assign ecv[3] = {12'b0, if3.error_counter};  assign wcv[3] = {12'b0, if3.word_ct};

   typedef struct packed {
      logic [N-1:0][1:0]  sym;
      logic [N-1:0][1:0]  err;
      logic [N-1:0][15:0] ec;
      logic [N-1:0][15:0] wc;
   } exp_t;

   exp_t q[$];

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s[dut%0d]: got %0h expected %0h at %0t", name, k, act, expv, $time);
      end
   endtask

   // Reference model: plain integer bookkeeping of the channel rules.
   int thr  [N] = '{0, 16, 256, 256};
   int mg   [N] = '{8, 8, 8, 1};
   int cmax [N] = '{65535, 65535, 65535, 15};
   int m_lfsr [N];
   int m_st   [N];   // 0 idle, 1 armed, 2 holding off
   int m_gap  [N];
   int m_ec   [N];
   int m_wc   [N];

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_lfsr[k] = 32'hACE1;
         m_st[k]   = 0;
         m_gap[k]  = 0;
         m_ec[k]   = 0;
         m_wc[k]   = 0;
      end
   endtask

   task automatic model_step(input logic e, input logic [1:0] s, input logic i);
      exp_t x;
      int   mask;
      x = '0;
      for (int k = 0; k < N; k++) begin
         mask = 0;
         if (!i) begin
            m_st[k]  = 0;
            m_gap[k] = 0;
         end else if (m_st[k] == 0) begin
            m_st[k] = 1;
         end else if (e && m_st[k] == 1) begin
            if ((m_lfsr[k] % 256) < thr[k]) begin
               mask = ((m_lfsr[k] / 256) % 2 == 1) ? 2 : 1;
`ifdef ERR_BURST_EN
               if ((m_lfsr[k] / 512) % 2 == 1) mask = 3;
`endif
               m_st[k]  = 2;
               m_gap[k] = mg[k];
            end
         end else if (e && m_st[k] == 2) begin
            m_gap[k] = m_gap[k] - 1;
            if (m_gap[k] == 0) m_st[k] = 1;
         end
         if (e) begin
            m_lfsr[k] = (m_lfsr[k] / 2) ^ ((m_lfsr[k] % 2 == 1) ? 32'hB400 : 0);
            m_wc[k]   = min2(m_wc[k] + 1, cmax[k]);
            m_ec[k]   = min2(m_ec[k] + (mask % 2) + (mask / 2), cmax[k]);
            x.sym[k]  = s ^ 2'(mask);
            x.err[k]  = 2'(mask);
            x.ec[k]   = 16'(m_ec[k]);
            x.wc[k]   = 16'(m_wc[k]);
         end
      end
      if (e) q.push_back(x);
   endtask

   task automatic drive(input logic e, input logic [1:0] s, input logic i);
      en  = e;
      sym = s;
      inj = i;
      @(posedge clk);
      model_step(e, s, i);
      #1;
   endtask

   // Monitor: pops one expectation per valid output and checks every instance.
   bit         phase_a = 0;
   bit         replay  = 0;
   int         idx     = 0;
   logic [1:0] rec [300];

   always @(negedge clk) begin
      exp_t e;
      bit   have;
      if (rst) begin
         have = (q.size() > 0);
         for (int k = 0; k < N; k++) chk("valid_o", k, 32'(v[k]), 32'(have));
         if (have) begin
            e = q.pop_front();
            for (int k = 0; k < N; k++) begin
               chk("sym_o", k, 32'(so[k]), 32'(e.sym[k]));
               chk("err_inj", k, 32'(ei[k]), 32'(e.err[k]));
               chk("error_counter", k, 32'(ecv[k]), 32'(e.ec[k]));
               chk("word_ct", k, 32'(wcv[k]), 32'(e.wc[k]));
`ifndef ERR_BURST_EN
               chk("no_burst", k, 32'(ei[k] == 2'b11), 32'd0);
`endif
            end
            chk("thresh0_clean", 0, 32'(ei[0]), 32'd0);
            if (phase_a && idx < 300) begin
               chk("inj_every_9", 2, 32'(ei[2] != 2'b00), 32'(idx % 9 == 0));
               chk("inj_every_2", 3, 32'(ei[3] != 2'b00), 32'(idx % 2 == 0));
               if (replay) chk("replay_err", 1, 32'(ei[1]), 32'(rec[idx]));
               else        rec[idx] = e.err[1];
               idx++;
            end
         end else begin
            for (int k = 0; k < N; k++) chk("idle_err_inj", k, 32'(ei[k]), 32'd0);
         end
      end
   end

   task automatic check_zero(input string name);
      for (int k = 0; k < N; k++) begin
         chk({name, "_sym_o"}, k, 32'(so[k]), 32'd0);
         chk({name, "_valid_o"}, k, 32'(v[k]), 32'd0);
         chk({name, "_err_inj"}, k, 32'(ei[k]), 32'd0);
         chk({name, "_error_counter"}, k, 32'(ecv[k]), 32'd0);
         chk({name, "_word_ct"}, k, 32'(wcv[k]), 32'd0);
      end
   endtask

   // 300 accepted symbols with inj_en_i held high and random idle cycles mixed in.
   task automatic run_a(input bit is_replay);
      int sent;
      idx     = 0;
      replay  = is_replay;
      drive(1'b0, 2'b00, 1'b1);
      phase_a = 1;
      sent    = 0;
      while (sent < 300) begin
         if ($urandom_range(0, 4) == 0) drive(1'b0, 2'($urandom), 1'b1);
         else begin
            drive(1'b1, 2'($urandom), 1'b1);
            sent++;
         end
      end
      drive(1'b0, 2'b00, 1'b1);
      phase_a = 0;
      chk("end_word_ct", 0, 32'(wcv[0]), 32'd300);
      chk("end_error_counter", 0, 32'(ecv[0]), 32'd0);
      chk("end_word_ct", 2, 32'(wcv[2]), 32'd300);
`ifndef ERR_BURST_EN
      chk("end_error_counter", 2, 32'(ecv[2]), 32'd34);
`endif
      chk("end_word_ct_sat", 3, 32'(wcv[3]), 32'd15);
      chk("end_error_counter_sat", 3, 32'(ecv[3]), 32'd15);
      chk("inj_index_count", 2, 32'(idx), 32'd300);
   endtask

   task automatic run_b(input int cycles);
      for (int c = 0; c < cycles; c++)
         drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom_range(0, 9) != 0));
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b1;
      run_a(1'b0);
      run_b(400);

      // Mid-stream asynchronous reset after 50 more accepted symbols.
      for (int s = 0; s < 50; s++) drive(1'b1, 2'($urandom), 1'b1);
      #2;
      rst = 1'b0;
      q.delete();
      model_reset();
      #1;
      check_zero("async_reset");
      en  = 1'b0;
      inj = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b1;
      @(posedge clk);
      model_step(1'b0, 2'b00, 1'b0);
      #1;
      run_a(1'b1);
      run_b(200);
      drive(1'b0, 2'b00, 1'b0);
      drive(1'b0, 2'b00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/viterbi_channel_err_inj.md
Name: viterbi_channel_err_inj

Overview:
Channel model stage between the convolutional encoder and the Viterbi decoder in the tx/rx chain.
- Registers each 2-bit encoded symbol.
- Flips selected bits using a seeded LFSR, with a guaranteed error-free gap after each error so the decoder can correct it.
- Exports `err_inj`, `error_counter` and `word_ct` for the scoreboard.

Parameters:
- SYM_W, 2, encoded symbol width.
- CNT_W, 16, width of `word_ct` and `error_counter`.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- THRESH, 9'd16, injection threshold on `lfsr[7:0]`. Range 0..256: 0 means never inject, 256 means inject at every eligible symbol.
- MIN_GAP, 8, number of accepted symbols forced error-free after each injection; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable_i  in  1  `sym_i` valid this cycle.
- sym_i  in  SYM_W  encoded symbol from the encoder.
- inj_en_i  in  1  enables error injection.
- sym_o  out  SYM_W  channel symbol to the decoder.
- valid_o  out  1  `sym_o` valid.
- err_inj  out  SYM_W  mask XORed into the current `sym_o`.
- error_counter  out  CNT_W  number of bits flipped so far, saturating.
- word_ct  out  CNT_W  number of symbols accepted so far, saturating.

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-stream):
  - `sym_o`, `valid_o`, `err_inj`, `error_counter`, `word_ct` all go to 0.
  - lfsr := LFSR_SEED; state := IDLE; gap := 0.
- Latency is exactly 1 cycle:
  - On an edge with enable_i=1: sym_o <= sym_i ^ mask; err_inj <= mask; valid_o <= 1.
  - On an edge with enable_i=0: valid_o <= 0, err_inj <= 0, `sym_o` holds.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances only on accepted symbols. The mask decision uses the pre-advance value.
- State machine, evaluated on accepted symbols unless stated otherwise:
  - IDLE: mask=0. Next state is RUN when inj_en_i=1.
  - RUN: inject when inj_en_i=1 and {1'b0,lfsr[7:0]} < THRESH.
    - mask = lfsr[8] ? 2'b10 : 2'b01.
    - Then gap := MIN_GAP and go to HOLDOFF.
    - Otherwise mask=0 and stay in RUN.
  - HOLDOFF: mask=0; gap decrements by 1 per accepted symbol. Go to RUN when gap reaches 0 on that symbol, so the next eligible symbol is MIN_GAP+1 after the injection.
  - Any state with inj_en_i=0 sampled on any edge, accepted or not: go to IDLE, clear gap, mask=0 for that symbol.
- Counters:
  - `word_ct` increments by 1 per accepted symbol.
  - `error_counter` increments by popcount(mask).
  - Both saturate at all-ones and never wrap.
  - Injection decisions continue after saturation.
- Simultaneous events: enable_i=1 with inj_en_i falling on the same edge gives no injection; the symbol still passes and is counted.

Optional Feature:
- Macro: `ERR_BURST_EN`.
- Defined: in RUN, when an injection fires and lfsr[9]=1, mask=2'b11 (double-bit burst) and `error_counter` adds 2, saturating. Otherwise the single-bit rule applies.
- Undefined: the mask is never 2'b11, and lfsr[9] is ignored.

Test Plan:
1. THRESH=0, inj_en_i=1, 100 random symbols → `sym_o` equals `sym_i` delayed 1 cycle, `err_inj`=0 throughout, error_counter=0, word_ct=100.
2. THRESH=256, MIN_GAP=8, inj_en_i=1, 300 consecutive symbols → injections exactly at symbol indices 0,9,18,…,297; error_counter=34 (single-bit build); each `err_inj` is 01 or 10.
3. THRESH=256, MIN_GAP=8; enable_i idle for 5 cycles between symbols 3 and 4 → idle cycles neither decrement gap nor advance the LFSR; next injection still at symbol 9.
4. THRESH=256; drop inj_en_i for one cycle in HOLDOFF, then raise it → the first accepted symbol after re-entering RUN is injected; gap is not resumed.
5. CNT_W=4, THRESH=256, MIN_GAP=1, 40 symbols → word_ct=15, error_counter=15, no wrap.
6. Assert rst low mid-stream after 50 symbols, then release → all outputs 0 immediately (asynchronous); the LFSR sequence and injection indices replay identically to a fresh start.
